// File: rtl/regfile_2w2r_if.sv
// Bundles the register file's control, write, read and status signals.
// Pure wiring: adds no latency.
// No backpressure: every signal is sampled or driven every cycle.
interface regfile_2w2r_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             flush;
    logic             wr_a;
    logic [AW-1:0]    wr_addr_a;
    logic [WIDTH-1:0] d_in_a;
    logic             wr_b;
    logic [AW-1:0]    wr_addr_b;
    logic [WIDTH-1:0] d_in_b;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] d_out_a;
    logic [WIDTH-1:0] d_out_b;
    logic             vld_a;
    logic             vld_b;
    logic             wr_collide;

    // Decode/writeback side: drives addresses and write data, observes read results.
    modport master (
        output flush, wr_a, wr_addr_a, d_in_a, wr_b, wr_addr_b, d_in_b,
               rd_addr_a, rd_addr_b,
        input  d_out_a, d_out_b, vld_a, vld_b, wr_collide
    );

    // Register file side.
    modport slave (
        input  flush, wr_a, wr_addr_a, d_in_a, wr_b, wr_addr_b, d_in_b,
               rd_addr_a, rd_addr_b,
        output d_out_a, d_out_b, vld_a, vld_b, wr_collide
    );
endinterface

// File: rtl/regfile_2w2r.sv
// Two-write/two-read register file with per-entry valid scoreboard and optional bypass/zero register.
// Reads combinational (0 cycles); writes visible next cycle (same cycle with BYPASS); wr_collide 1 cycle late.
// No backpressure: both write ports always accepted; on a same-address collision port B wins.
module regfile_2w2r #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    regfile_2w2r_if.slave  rf_if
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic             r_collide;

    logic             w_we_a;
    logic             w_we_b;
    logic             w_collide;
    logic [DEPTH-1:0] w_vld_nxt;
    logic [WIDTH-1:0] w_dout_a;
    logic [WIDTH-1:0] w_dout_b;
    logic             w_vld_a;
    logic             w_vld_b;

    // Effective write enables: gated by reset (so bypass is also quiet in reset)
    // and suppressed for address 0 when it is the hardwired zero register.
    assign w_we_a = i_rst_n && rf_if.wr_a
                    && !((ZERO_REG != 0) && (rf_if.wr_addr_a == AW'(0)));
    assign w_we_b = i_rst_n && rf_if.wr_b
                    && !((ZERO_REG != 0) && (rf_if.wr_addr_b == AW'(0)));
    assign w_collide = w_we_a && w_we_b && (rf_if.wr_addr_a == rf_if.wr_addr_b);

    // Data storage: port A is dropped on collision so port B's data lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we_a && !w_collide) begin
                r_mem[rf_if.wr_addr_a] <= rf_if.d_in_a;
            end
            if (w_we_b) begin
                r_mem[rf_if.wr_addr_b] <= rf_if.d_in_b;
            end
        end
    end

    // Next valid vector: flush clears everything, then this edge's writes set their bits.
    always_comb begin
        w_vld_nxt = rf_if.flush ? '0 : r_vld;
        if (w_we_a) begin
            w_vld_nxt[rf_if.wr_addr_a] = 1'b1;
        end
        if (w_we_b) begin
            w_vld_nxt[rf_if.wr_addr_b] = 1'b1;
        end
    end

    // Valid scoreboard and collision flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld     <= '0;
            r_collide <= 1'b0;
        end else begin
            r_vld     <= w_vld_nxt;
            r_collide <= w_collide;
        end
    end

    // Read port A: storage, optionally forwarded from an in-flight write (B first), zero reg last.
    always_comb begin
        w_dout_a = r_mem[rf_if.rd_addr_a];
        w_vld_a  = r_vld[rf_if.rd_addr_a];
        if (BYPASS != 0) begin
            if (w_we_b && (rf_if.wr_addr_b == rf_if.rd_addr_a)) begin
                w_dout_a = rf_if.d_in_b;
                w_vld_a  = 1'b1;
            end else if (w_we_a && (rf_if.wr_addr_a == rf_if.rd_addr_a)) begin
                w_dout_a = rf_if.d_in_a;
                w_vld_a  = 1'b1;
            end
        end
        if ((ZERO_REG != 0) && (rf_if.rd_addr_a == AW'(0))) begin
            w_dout_a = '0;
            w_vld_a  = 1'b1;
        end
    end

    // Read port B: same selection as port A, independent address.
    always_comb begin
        w_dout_b = r_mem[rf_if.rd_addr_b];
        w_vld_b  = r_vld[rf_if.rd_addr_b];
        if (BYPASS != 0) begin
            if (w_we_b && (rf_if.wr_addr_b == rf_if.rd_addr_b)) begin
                w_dout_b = rf_if.d_in_b;
                w_vld_b  = 1'b1;
            end else if (w_we_a && (rf_if.wr_addr_a == rf_if.rd_addr_b)) begin
                w_dout_b = rf_if.d_in_a;
                w_vld_b  = 1'b1;
            end
        end
        if ((ZERO_REG != 0) && (rf_if.rd_addr_b == AW'(0))) begin
            w_dout_b = '0;
            w_vld_b  = 1'b1;
        end
    end

    assign rf_if.d_out_a    = w_dout_a;
    assign rf_if.d_out_b    = w_dout_b;
    assign rf_if.vld_a      = w_vld_a;
    assign rf_if.vld_b      = w_vld_b;
    assign rf_if.wr_collide = r_collide;

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench: 16x8 without bypass, 16x8 with bypass, 32x32 zero-register with bypass.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Same stimulus drives both 16x8 instances so their differences isolate the bypass path.
module tb_regfile_2w2r;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_2w2r_if #(.WIDTH(16), .AW(3)) if0 ();
    regfile_2w2r_if #(.WIDTH(16), .AW(3)) if1 ();
    regfile_2w2r_if #(.WIDTH(32), .AW(5)) if2 ();

    regfile_2w2r #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
        .i_clk(clk), .i_rst_n(rst_n), .rf_if(if0)
    );
    regfile_2w2r #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u_byp (
        .i_clk(clk), .i_rst_n(rst_n), .rf_if(if1)
    );
    regfile_2w2r #(.WIDTH(32), .DEPTH(32), .BYPASS(1), .ZERO_REG(1)) u_zero (
        .i_clk(clk), .i_rst_n(rst_n), .rf_if(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive both 16x8 instances identically.
    task automatic drv16(input logic fl,
                         input logic wa, input logic [2:0] aa, input logic [15:0] da,
                         input logic wb, input logic [2:0] ab, input logic [15:0] db,
                         input logic [2:0] ra, input logic [2:0] rb);
        if0.flush = fl; if0.wr_a = wa; if0.wr_addr_a = aa; if0.d_in_a = da;
        if0.wr_b = wb;  if0.wr_addr_b = ab; if0.d_in_b = db;
        if0.rd_addr_a = ra; if0.rd_addr_b = rb;
        if1.flush = fl; if1.wr_a = wa; if1.wr_addr_a = aa; if1.d_in_a = da;
        if1.wr_b = wb;  if1.wr_addr_b = ab; if1.d_in_b = db;
        if1.rd_addr_a = ra; if1.rd_addr_b = rb;
    endtask

    task automatic drv32(input logic fl,
                         input logic wa, input logic [4:0] aa, input logic [31:0] da,
                         input logic wb, input logic [4:0] ab, input logic [31:0] db,
                         input logic [4:0] ra, input logic [4:0] rb);
        if2.flush = fl; if2.wr_a = wa; if2.wr_addr_a = aa; if2.d_in_a = da;
        if2.wr_b = wb;  if2.wr_addr_b = ab; if2.d_in_b = db;
        if2.rd_addr_a = ra; if2.rd_addr_b = rb;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd0, 3'd0);
        drv32(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd1);
        #2;
        // Reset state
        chk("rst_nobyp_dout_a", 32'(if0.d_out_a), 32'h0);
        chk("rst_nobyp_vld_a",  32'(if0.vld_a), 32'h0);
        chk("rst_nobyp_collide", 32'(if0.wr_collide), 32'h0);
        chk("rst_byp_vld_b",    32'(if1.vld_b), 32'h0);
        chk("rst_zero_vld0",    32'(if2.vld_a), 32'h1);
        chk("rst_zero_dout0",   if2.d_out_a, 32'h0);
        chk("rst_zero_vld1",    32'(if2.vld_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-cycle reset after writing 0xBEEF to entry 3
        tick();
        drv16(0, 1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0, 3'd3, 3'd3);
        tick();
        drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd3, 3'd3);
        #1;
        chk("pre_rst_dout3", 32'(if0.d_out_a), 32'hBEEF);
        chk("pre_rst_vld3",  32'(if0.vld_b), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_nobyp_dout3", 32'(if0.d_out_a), 32'h0);
        chk("midrst_nobyp_vld3",  32'(if0.vld_a), 32'h0);
        chk("midrst_byp_dout3",   32'(if1.d_out_b), 32'h0);
        chk("midrst_byp_vld3",    32'(if1.vld_b), 32'h0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
            #0.1;
            chk("post_rst_dout_a", 32'(if0.d_out_a), 32'h0);
            chk("post_rst_vld_a",  32'(if0.vld_a), 32'h0);
            chk("post_rst_vld_b",  32'(if1.vld_b), 32'h0);
        end

        // Dual write to distinct addresses
        tick();
        drv16(0, 1, 3'd2, 16'h1234, 1, 3'd5, 16'hABCD, 3'd2, 3'd5);
        #1;
        chk("dual_nobyp_same_cycle_a", 32'(if0.d_out_a), 32'h0);
        chk("dual_byp_same_cycle_a",   32'(if1.d_out_a), 32'h1234);
        chk("dual_byp_same_cycle_b",   32'(if1.d_out_b), 32'hABCD);
        tick();
        drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd2, 3'd5);
        #1;
        chk("dual_dout_a", 32'(if0.d_out_a), 32'h1234);
        chk("dual_vld_a",  32'(if0.vld_a), 32'h1);
        chk("dual_dout_b", 32'(if0.d_out_b), 32'hABCD);
        chk("dual_vld_b",  32'(if0.vld_b), 32'h1);
        chk("dual_collide", 32'(if0.wr_collide), 32'h0);

        // Collision on entry 4: port B wins
        tick();
        drv16(0, 1, 3'd4, 16'h1111, 1, 3'd4, 16'h2222, 3'd4, 3'd4);
        #1;
        chk("coll_byp_same_cycle", 32'(if1.d_out_a), 32'h2222);
        chk("coll_flag_not_yet",   32'(if0.wr_collide), 32'h0);
        tick();
        drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd4, 3'd4);
        #1;
        chk("coll_nobyp_data", 32'(if0.d_out_a), 32'h2222);
        chk("coll_byp_data",   32'(if1.d_out_b), 32'h2222);
        chk("coll_flag_nobyp", 32'(if0.wr_collide), 32'h1);
        chk("coll_flag_byp",   32'(if1.wr_collide), 32'h1);
        tick();
        chk("coll_flag_clear", 32'(if0.wr_collide), 32'h0);

        // Bypass vs. no bypass on entry 6
        drv16(0, 1, 3'd6, 16'h0001, 0, 3'd0, 16'h0, 3'd6, 3'd6);
        tick();
        drv16(0, 1, 3'd6, 16'h00FF, 0, 3'd0, 16'h0, 3'd6, 3'd0);
        #1;
        chk("byp0_same_cycle", 32'(if0.d_out_a), 32'h0001);
        chk("byp1_same_cycle", 32'(if1.d_out_a), 32'h00FF);
        chk("byp1_vld",        32'(if1.vld_a), 32'h1);
        tick();
        drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd6, 3'd0);
        #1;
        chk("byp0_after_edge", 32'(if0.d_out_a), 32'h00FF);
        chk("byp1_after_edge", 32'(if1.d_out_a), 32'h00FF);

        // Flush with concurrent write to entry 1; entry 7 loses valid, keeps data
        drv16(0, 1, 3'd1, 16'h0A0A, 1, 3'd7, 16'h7777, 3'd1, 3'd7);
        tick();
        drv16(1, 1, 3'd1, 16'h5555, 0, 3'd0, 16'h0, 3'd1, 3'd7);
        #1;
        chk("flush_nobyp_pre_dout1", 32'(if0.d_out_a), 32'h0A0A);
        chk("flush_nobyp_pre_vld7",  32'(if0.vld_b), 32'h1);
        chk("flush_byp_vld1",        32'(if1.vld_a), 32'h1);
        chk("flush_byp_dout1",       32'(if1.d_out_a), 32'h5555);
        tick();
        drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd1, 3'd7);
        #1;
        chk("flush_vld1",  32'(if0.vld_a), 32'h1);
        chk("flush_dout1", 32'(if0.d_out_a), 32'h5555);
        chk("flush_vld7",  32'(if0.vld_b), 32'h0);
        chk("flush_dout7", 32'(if0.d_out_b), 32'h7777);
        chk("flush_byp_vld7", 32'(if1.vld_b), 32'h0);
        drv16(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd2, 3'd5);
        #1;
        chk("flush_vld2", 32'(if0.vld_a), 32'h0);
        chk("flush_dout2_kept", 32'(if0.d_out_a), 32'h1234);

        // Zero register: both ports write address 0
        drv32(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        #1;
        chk("zero_no_bypass_dout", if2.d_out_a, 32'h0);
        chk("zero_no_bypass_vld",  32'(if2.vld_b), 32'h1);
        tick();
        drv32(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("zero_dout",    if2.d_out_a, 32'h0);
        chk("zero_vld",     32'(if2.vld_a), 32'h1);
        chk("zero_collide", 32'(if2.wr_collide), 32'h0);

        // Wide config: collision at entry 31, normal write to 17
        drv32(0, 1, 5'd31, 32'hAAAA0001, 1, 5'd31, 32'hBBBB0002, 5'd31, 5'd17);
        tick();
        drv32(0, 1, 5'd17, 32'hC0FFEE17, 0, 5'd0, 32'h0, 5'd31, 5'd17);
        #1;
        chk("wide_coll_data",  if2.d_out_a, 32'hBBBB0002);
        chk("wide_coll_flag",  32'(if2.wr_collide), 32'h1);
        chk("wide_byp17",      if2.d_out_b, 32'hC0FFEE17);
        tick();
        drv32(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd31, 5'd17);
        #1;
        chk("wide_dout17",     if2.d_out_b, 32'hC0FFEE17);
        chk("wide_vld17",      32'(if2.vld_b), 32'h1);
        chk("wide_coll_clear", 32'(if2.wr_collide), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised multi-port register file. It supersedes the fixed 8×16 one-write/two-read register array in the datapath and adds:
- a second write port with defined collision priority
- optional same-cycle write-to-read forwarding
- a per-entry valid scoreboard with a synchronous flush
- an optional hardwired zero register

It sits between the decode stage (read addresses) and the writeback stage (two retirement writes per cycle).

## Interface
Parameters:
- WIDTH, 16, data bits per entry (≥1)
- DEPTH, 8, number of entries (power of two, ≥2); AW = log2(DEPTH)
- BYPASS, 0, 1 = a read of an address being written this cycle returns the incoming write data
- ZERO_REG, 0, 1 = entry 0 always reads 0, ignores writes, and always reads valid

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all entries and valid bits immediately
- flush  in  1  synchronous; clears all valid bits at next edge (data retained)
- wr_a  in  1  write enable, port A
- wr_addr_a  in  AW  write address, port A
- d_in_a  in  WIDTH  write data, port A
- wr_b  in  1  write enable, port B (priority port)
- wr_addr_b  in  AW  write address, port B
- d_in_b  in  WIDTH  write data, port B
- rd_addr_a  in  AW  read address, port A
- rd_addr_b  in  AW  read address, port B
- d_out_a  out  WIDTH  read data, port A
- d_out_b  out  WIDTH  read data, port B
- vld_a  out  1  valid bit of entry rd_addr_a
- vld_b  out  1  valid bit of entry rd_addr_b
- wr_collide  out  1  registered; 1 for one cycle after a cycle where wr_a & wr_b & (wr_addr_a == wr_addr_b)

## Operation
- Storage: DEPTH × WIDTH registers plus DEPTH valid flops.
- Write: on a rising edge with wr_x=1, entry wr_addr_x ← d_in_x and valid[wr_addr_x] ← 1.
- Both ports writing different addresses: both writes complete in the same edge.
- Both ports writing the same address: port B data is stored, port A is dropped, and wr_collide is set for the next cycle.
- Flush: at the edge, all valid bits ← 0, except entries written that same edge, which end valid=1 (write beats flush). Data is unchanged.
- Read: combinational from storage. d_out_x = entry[rd_addr_x]; vld_x = valid[rd_addr_x]. Both read ports are independent and may use the same address.
- BYPASS=1, when rd_addr_x matches an enabled write address in the same cycle:
  - d_out_x = d_in of the matching write; port B's data if both writes match
  - vld_x = 1
  - a concurrent flush does not suppress the bypassed vld_x
- BYPASS=0: reads always return the pre-edge stored value.
- ZERO_REG=1: writes to address 0 are ignored (no valid update, no collision flagged). Reads of address 0 give d_out=0 and vld=1, and are never bypassed.

## Timing
- Reset (reset=0, asynchronous): all entries 0, all valid 0, wr_collide 0. Therefore d_out_a/b=0 and vld_a/b=0 (vld=1 at address 0 if ZERO_REG). Writes, flushes and collide reporting are all inhibited while reset=0.
- Reset asserted mid-cycle between edges: state clears immediately. The first edge after release (reset=1) is the first functional edge.
- Write latency: data is readable 1 cycle after the write edge; with BYPASS=1 it is visible combinationally in the same cycle.
- wr_collide latency: 1 cycle; self-clears if no collision on the following cycle.
- Read path: purely combinational, no added latency.
- Address wrap: none needed; AW exactly covers DEPTH.

## Test plan
- Reset/reset-release (WIDTH=16, DEPTH=8): drive reset=0 mid-cycle after writing 0xBEEF to entry 3 → d_out and vld read 0 immediately. After release, every entry reads 0 with vld=0.
- Dual write, distinct addresses: wr_a to addr 2 with 0x1234 and wr_b to addr 5 with 0xABCD in one edge → next cycle, rd_addr_a=2 reads 0x1234 with vld_a=1, rd_addr_b=5 reads 0xABCD with vld_b=1.
- Collision: both ports write addr 4, A=0x1111, B=0x2222 → entry 4 reads 0x2222, and wr_collide=1 for exactly one cycle, then 0.
- Bypass (BYPASS=1): entry 6 holds 0x0001; write 0x00FF to addr 6 with rd_addr_a=6 in the same cycle → d_out_a=0x00FF in that cycle. With BYPASS=0 → 0x0001 in that cycle and 0x00FF after the edge.
- Flush vs write: entries 1 and 7 valid; assert flush together with wr_a to addr 1 (0x5555) → after the edge, vld for entry 1 is 1 (data 0x5555), vld for entry 7 is 0, and entry 7's data is retained.
- ZERO_REG=1, DEPTH=32, WIDTH=32: write 0xFFFFFFFF to addr 0 → d_out=0, vld=1, wr_collide stays 0 even if both ports target addr 0.
